// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write controller: frame layout,
// peripheral register map, FSM states and small elaboration helpers.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;
    localparam int DATA_LSB   = 0;

    localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Read frames carry zeros in the data field so the peripheral sees a clean command.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       write,
        input logic [6:0] addr,
        input logic [7:0] wdata
    );
        logic [FRAME_BITS-1:0] frame;
        frame                    = '0;
        frame[RW_BIT]            = write;
        frame[ADDR_MSB:ADDR_LSB] = addr;
        frame[DATA_MSB:DATA_LSB] = write ? wdata : 8'h00;
        return frame;
    endfunction

endpackage

// File: rtl/spi_controller_sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous inputs into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI initiator: serialises one 16-bit register frame per valid/ready
// request and returns the data byte captured on cipo for read frames.
module spi_controller
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int CS_SETUP    = 4,
    parameter int CS_HOLD     = 4,
    parameter int CS_IDLE     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ncs,
    output logic       sclk,
    output logic       copi,
    input  logic       cipo
);

    localparam int CNT_MAX = max_of(max_of(HALF_PERIOD, CS_SETUP), max_of(CS_HOLD, CS_IDLE));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] HP_LAST    = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [7:0]              cap_q, cap_d;
    logic                    write_q, write_d;
    logic                    ncs_q, ncs_d;
    logic                    sclk_q, sclk_d;
    logic                    copi_q, copi_d;
    logic                    done_q, done_d;
    logic [7:0]              rdata_q, rdata_d;
    logic                    cipo_sync;

    sync_2ff #(
        .WIDTH(1)
    ) u_cipo_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (cipo),
        .q_o  (cipo_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            cap_q     <= '0;
            write_q   <= 1'b0;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            cap_q     <= cap_d;
            write_q   <= write_d;
            ncs_q     <= ncs_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
        end
    end

    // bit_cnt_q counts completed HIGH phases, so phase N is active while it holds N-1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cap_d     = cap_q;
        write_d   = write_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    state_d   = SETUP;
                    shift_d   = build_frame(req_write, req_addr, req_wdata);
                    write_d   = req_write;
                    bit_cnt_d = '0;
                    cap_d     = '0;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end
            end
            HIGH: begin
                if (cnt_q == HP_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q >= 5'd8) begin
                        cap_d = {cap_q[6:0], cipo_sync};
                    end
                    if (bit_cnt_q == 5'd15) begin
                        state_d = HOLD;
                    end else begin
                        state_d = LOW;
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            LOW: begin
                if (cnt_q == HP_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (!write_q) begin
                        rdata_d = cap_q;
                    end
                end
            end
            GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pins are decoded from the next state so they change on the same edge as the FSM.
        ncs_d  = !(state_d inside {SETUP, HIGH, LOW, HOLD});
        sclk_d = (state_d == HIGH);
        copi_d = (state_d inside {SETUP, HIGH, LOW}) ? shift_d[FRAME_BITS-1] : 1'b0;
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign ncs       = ncs_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench: default-timing controller with an SPI monitor and cipo model,
// plus a HALF_PERIOD=8 / CS_SETUP=2 instance for phase-timing checks.
module tb_spi_controller;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       busy, done, ncs, sclk, copi;
    logic [7:0] rdata;
    logic       cipo = 1'b0;

    logic       b_req_valid = 1'b0;
    logic       b_req_ready;
    logic       b_req_write = 1'b0;
    logic [6:0] b_req_addr = '0;
    logic [7:0] b_req_wdata = '0;
    logic       b_busy, b_done, b_ncs, b_sclk, b_copi;
    logic [7:0] b_rdata;
    logic       b_cipo = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cipo_data = 8'h3C;

    always #5 clk = ~clk;

    spi_controller u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata(rdata),
        .ncs(ncs), .sclk(sclk), .copi(copi), .cipo(cipo)
    );

    spi_controller #(.HALF_PERIOD(8), .CS_SETUP(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .busy(b_busy), .done(b_done), .rdata(b_rdata),
        .ncs(b_ncs), .sclk(b_sclk), .copi(b_copi), .cipo(b_cipo)
    );

    // Monitor + peripheral model for the default-timing instance
    logic        a_ncs_prev = 1'b1, a_sclk_prev = 1'b0, a_copi_prev = 1'b0;
    int          a_rises = 0, a_falls = 0, a_low_cnt = 0, a_high_run = 0, a_gap = 0;
    int          a_done_cnt = 0, a_ready_viol = 0, a_copi_viol = 0;
    logic [15:0] a_frame = '0;

    always @(negedge clk) begin
        a_ncs_prev  <= ncs;
        a_sclk_prev <= sclk;
        a_copi_prev <= copi;
        if (done) a_done_cnt <= a_done_cnt + 1;
        if (!ncs) begin
            if (req_ready) a_ready_viol <= a_ready_viol + 1;
            if (a_ncs_prev) begin
                a_low_cnt <= 1;
                a_gap     <= a_high_run;
                a_rises   <= 0;
                a_falls   <= 0;
                a_frame   <= '0;
                cipo      <= 1'b0;
            end else begin
                a_low_cnt <= a_low_cnt + 1;
                if (sclk && !a_sclk_prev) begin
                    a_rises <= a_rises + 1;
                    a_frame <= {a_frame[14:0], copi};
                end
                if (!sclk && a_sclk_prev) begin
                    a_falls <= a_falls + 1;
                    if (a_falls + 1 >= 8 && a_falls + 1 <= 15)
                        cipo <= cipo_data[15 - (a_falls + 1)];
                    else
                        cipo <= 1'b0;
                end
                if (sclk && a_sclk_prev && copi != a_copi_prev) a_copi_viol <= a_copi_viol + 1;
            end
        end else begin
            a_high_run <= a_ncs_prev ? a_high_run + 1 : 1;
            cipo       <= 1'b0;
        end
    end

    // Monitor for the slow instance: frame decode plus phase-length checks
    logic        b_ncs_prev = 1'b1, b_sclk_prev = 1'b0, b_copi_prev = 1'b0;
    int          b_rises = 0, b_low_cnt = 0, b_since = 0, b_first = 0, b_run = 0;
    int          b_phase_viol = 0, b_copi_viol = 0;
    logic [15:0] b_frame = '0;

    always @(negedge clk) begin
        b_ncs_prev  <= b_ncs;
        b_sclk_prev <= b_sclk;
        b_copi_prev <= b_copi;
        b_run       <= (b_sclk != b_sclk_prev) ? 1 : b_run + 1;
        if (!b_ncs) begin
            if (b_ncs_prev) begin
                b_low_cnt <= 1;
                b_since   <= 1;
                b_rises   <= 0;
                b_frame   <= '0;
            end else begin
                b_low_cnt <= b_low_cnt + 1;
                if (!b_sclk && b_rises == 0) b_since <= b_since + 1;
                if (b_sclk && !b_sclk_prev) begin
                    b_rises <= b_rises + 1;
                    b_frame <= {b_frame[14:0], b_copi};
                    if (b_rises == 0) b_first <= b_since;
                    else if (b_run != 8) b_phase_viol <= b_phase_viol + 1;
                end
                if (!b_sclk && b_sclk_prev && b_run != 8) b_phase_viol <= b_phase_viol + 1;
                if (b_sclk && b_sclk_prev && b_copi != b_copi_prev) b_copi_viol <= b_copi_viol + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        @(negedge clk);
        while (!done && n < 1000) begin @(negedge clk); n++; end
        if (!done) timeout_fail(tag);
    endtask

    task automatic wait_accept_a(input string tag);
        int n = 0;
        while (!req_ready && n < 1000) begin @(negedge clk); n++; end
        while (req_ready && n < 1000) begin @(negedge clk); n++; end
        if (req_ready) timeout_fail(tag);
    endtask

    task automatic issue_a(input logic w, input logic [6:0] a, input logic [7:0] d, input string tag);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        wait_accept_a(tag);
        req_valid = 1'b0;
    endtask

    initial begin
        int snap;
        int hits;
        int n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ncs", ncs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_copi", copi, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_ready", req_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x04 / 0xA5
        issue_a(1'b1, REG_PWM_DUTY, 8'hA5, "wr1_accept");
        check("wr1_busy", busy, 1);
        wait_done_a("wr1_done");
        #1;
        check("wr1_frame", a_frame, 16'h84A5);
        check("wr1_rises", a_rises, 16);
        check("wr1_ncs_low", a_low_cnt, 132);
        check("wr1_rdata", rdata, 8'h00);
        @(negedge clk);
        check("wr1_done_width", done, 0);
        check("wr1_ready_viol", a_ready_viol, 0);
        check("wr1_copi_stable", a_copi_viol, 0);

        // Read 0x02, peripheral returns 0x3C
        repeat (6) @(negedge clk);
        issue_a(1'b0, REG_EN_PWM_7_0, 8'hEE, "rd_accept");
        wait_done_a("rd_done");
        check("rd_rdata", rdata, 8'h3C);
        #1;
        check("rd_frame", a_frame, 16'h0200);
        check("rd_rises", a_rises, 16);
        @(negedge clk);
        check("rd_done_width", done, 0);

        // Back-to-back writes with req_valid held high
        repeat (6) @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = REG_EN_OUT_7_0;
        req_wdata = 8'hFF;
        wait_accept_a("b2b1_accept");
        req_addr  = REG_EN_OUT_15_8;
        req_wdata = 8'h0F;
        wait_done_a("b2b1_done");
        #1;
        check("b2b1_frame", a_frame, 16'h80FF);
        wait_accept_a("b2b2_accept");
        req_valid = 1'b0;
        #1;
        check("b2b_gap_ge4", (a_gap >= 4), 1);
        wait_done_a("b2b2_done");
        #1;
        check("b2b2_frame", a_frame, 16'h810F);
        check("b2b_ready_viol", a_ready_viol, 0);
        check("b2b_rdata_kept", rdata, 8'h3C);

        // Reset after the 7th sclk rise drops the frame
        repeat (6) @(negedge clk);
        issue_a(1'b1, REG_EN_PWM_15_8, 8'h55, "rst_accept");
        n = 0;
        #1;
        while (a_rises < 7 && n < 1000) begin @(negedge clk); #1; n++; end
        if (a_rises < 7) timeout_fail("rst_wait_rise7");
        snap  = a_done_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_ncs", ncs, 1);
        check("midrst_sclk", sclk, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("midrst_no_done", a_done_cnt, snap);
        check("midrst_rdata", rdata, 8'h00);
        issue_a(1'b1, REG_EN_PWM_7_0, 8'h33, "postrst_accept");
        wait_done_a("postrst_done");
        #1;
        check("postrst_frame", a_frame, 16'h8233);

        // Request raised while busy is ignored
        repeat (6) @(negedge clk);
        snap = a_done_cnt;
        issue_a(1'b1, REG_PWM_DUTY, 8'h11, "busy_accept");
        repeat (30) @(negedge clk);
        req_valid = 1'b1;
        req_addr  = REG_EN_OUT_15_8;
        req_wdata = 8'h22;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready) hits++;
        end
        req_valid = 1'b0;
        check("busy_no_ready", hits, 0);
        wait_done_a("busy_done");
        #1;
        check("busy_frame", a_frame, 16'h8411);
        repeat (20) @(negedge clk);
        #1;
        check("busy_idle_ncs", ncs, 1);
        check("busy_one_done", a_done_cnt - snap, 1);

        // Slow instance: HALF_PERIOD=8, CS_SETUP=2
        b_req_valid = 1'b1;
        b_req_write = 1'b1;
        b_req_addr  = REG_EN_OUT_15_8;
        b_req_wdata = 8'h77;
        @(negedge clk);
        b_req_valid = 1'b0;
        n = 0;
        while (!b_done && n < 2000) begin @(negedge clk); n++; end
        if (!b_done) timeout_fail("slow_done");
        #1;
        check("slow_frame", b_frame, 16'h8177);
        check("slow_rises", b_rises, 16);
        check("slow_first_rise", b_first, 2);
        check("slow_phase_len", b_phase_viol, 0);
        check("slow_copi_stable", b_copi_viol, 0);
        check("slow_ncs_low", b_low_cnt, 254);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI initiator that drives the team's 16-bit register-write frame onto ncs/sclk/copi for the on-chip SPI register peripheral, and the bench/FPGA-side equivalents.
- Accepts one register transaction at a time over a valid/ready request port and serialises it at a programmable sclk rate.
- Supports read frames: captures cipo during the data phase and returns it on rdata.
- Runs entirely in the system clk domain; all SPI outputs are registered.

Parameters:
HALF_PERIOD, 4, clk cycles per sclk phase (high or low); legal minimum 4, so the peripheral's 2-flop sync and edge detect see every edge
CS_SETUP, 4, clk cycles with ncs low and sclk low before the first sclk rise (≥1)
CS_HOLD, 4, clk cycles with ncs low and sclk low after the last sclk fall (≥1)
CS_IDLE, 4, minimum clk cycles ncs stays high between frames (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller idle and accepting
req_write  in  1  1 = write frame, 0 = read frame
req_addr  in  7  register address
req_wdata  in  8  write data (ignored for reads)
busy  out  1  frame in progress (ncs low or idle gap)
done  out  1  one-cycle pulse when a frame completes
rdata  out  8  data captured on the last read frame
ncs  out  1  chip select, active low
sclk  out  1  serial clock, idle low (mode 0)
copi  out  1  controller-out data
cipo  in  1  peripheral-out data (asynchronous)

Behaviour:
- Reset (async assert, sync deassert): ncs=1, sclk=0, copi=0, done=0, busy=0, rdata=0x00, req_ready=1, state IDLE. Asserting reset mid-frame forces ncs high immediately. No done pulse is issued; the frame is dropped.
- Frame format: 16 bits, MSB first: bit15 = R/W (1 = write), bits14:8 = addr, bits7:0 = wdata (write) or 0 (read).
- req_ready = (state==IDLE). Handshake: req_valid&&req_ready at a clk edge loads the shift register and enters SETUP. No request is accepted in any other state.
- States:
  - IDLE: ncs=1, sclk=0, copi=0.
  - SETUP: ncs=0, sclk=0, copi=bit15, held CS_SETUP cycles, then go to HIGH.
  - HIGH: sclk=1 for HALF_PERIOD cycles. The synchronised cipo is captured on the last cycle of the phase. After HIGH phases 1–15 go to LOW; after the 16th go to HOLD.
  - LOW: sclk=0 for HALF_PERIOD cycles. copi advances to the next bit on the first cycle of LOW, so it is stable ≥HALF_PERIOD cycles before the next rise.
  - HOLD: sclk=0, copi=0, ncs=0, held CS_HOLD cycles. Then ncs=1, done=1 for exactly that cycle, rdata updated (read frames only), go to GAP.
  - GAP: ncs=1 for CS_IDLE cycles total counting the done cycle, then IDLE.
- ncs low duration = CS_SETUP + 31*HALF_PERIOD + CS_HOLD (132 cycles at defaults). Exactly 16 sclk rising edges per frame.
- busy=1 in every state except IDLE.
- cipo: 2-flop synchroniser. HIGH phases 9–16 shift into an 8-bit capture register MSB first. rdata changes only at done of a read frame; write frames leave rdata unchanged.
- Counters: phase counter sized ceil(log2(max(HALF_PERIOD,CS_*)))+1. Bit counter is 5 bits (0–16), with no wrap.
- Back-to-back requests: req_valid held high is accepted on the first IDLE cycle after GAP. No frame may start with ncs high for fewer than CS_IDLE cycles.

Decomposition:
- spi_pkg: FRAME_BITS=16, RW_BIT=15, ADDR_MSB/LSB=14/8, DATA_MSB/LSB=7/0, register address constants (0x00 en_out_7_0 … 0x04 pwm_duty), state enum {IDLE,SETUP,HIGH,LOW,HOLD,GAP}.
- One natural sub-module: sync_2ff, a generic 2-flop synchroniser with async active-low reset, used for cipo and reusable by the peripheral.

Test Plan:
- Write addr 0x04 data 0xA5, HALF_PERIOD=4 → bench SPI monitor decodes frame 0x84A5 on sclk rises, exactly 16 rises, ncs low 132 cycles, one done pulse, rdata stays 0x00.
- Read addr 0x02 with cipo model driving 0x3C during the data phase → copi frame 0x0200, rdata=0x3C in the done cycle, done high exactly 1 cycle.
- req_valid held high with two writes (0x00/0xFF, then 0x01/0x0F) → second accepted only after ≥4 ncs-high cycles; monitor sees 0x80FF then 0x810F; req_ready low throughout each frame.
- rst_n pulsed low after the 7th sclk rise → ncs=1 and sclk=0 in the same cycle, no done, rdata=0x00; a following write completes normally.
- HALF_PERIOD=8, CS_SETUP=2 → every sclk high/low phase is exactly 8 cycles, first rise 2 cycles after ncs falls, copi never changes while sclk=1.
- req_valid asserted during busy → ignored (no ready), and a later frame carries only the request accepted in IDLE.
